dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the memory stage of the 5-stage RISC-V pipeline. Accepts one load or store per request from the M stage, applies a programmable number of wait states while holding the pipeline with `stallM`, and completes with sign/zero-extended load data or a byte-lane-masked store. It is the memory-side counterpart of the M-stage access signals (`ALUresM`, `memrwM`, `data_writeM`, `data_readM`).

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 2: stall cycles per aligned access; range 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `memreqM`  in  1  the M stage holds a load or store.
- `memrwM`  in  1  1 = store, 0 = load; qualified by `memreqM`.
- `funct3M`  in  3  RV32I width code.
- `ALUresM`  in  32  byte address.
- `data_writeM`  in  32  store data; low-order bytes are used.
- `data_readM`  out  32  load result; valid only in the completion cycle, 0 otherwise.
- `stallM`  out  1  hold the pipeline F/D/E/M stages.
- `errM`  out  1  one-cycle flag: misaligned address or illegal `funct3M`.

## Operation
- FSM states:
  - IDLE.
  - WAIT: a 4-bit counter tracks elapsed wait cycles.
  - DONE: completion cycle.
- Word index is `ALUresM[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Legal loads:
  - `000` LB and `001` LH are sign-extended.
  - `010` LW is a full word.
  - `100` LBU and `101` LHU are zero-extended.
- Legal stores are `000` SB, `001` SH and `010` SW.
- Byte lane is selected by `ALUresM[1:0]`. Halfword lane is selected by `ALUresM[1]`.
- Stores write only the enabled byte lanes. The other bytes of the word are unchanged.
- Error access:
  - Misaligned: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Illegal `funct3M`: any code not listed above for the access direction.
  - Effect: completes in the request cycle with `errM`=1, no stall, no array write, `data_readM`=0.
- Aligned request, with `WAIT_CYCLES`=W>0:
  - Accepted in IDLE at cycle T.
  - `stallM`=1 for cycles T..T+W-1.
  - Cycle T+W is the completion cycle with `stallM`=0. Load data is driven, or the store commits at the closing edge of T+W.
  - The FSM then returns to IDLE.
- With W=0, every aligned access completes in its request cycle and `stallM` stays 0.
- Request inputs are stable while `stallM`=1; the pipeline guarantees this.
- If `memreqM` drops during WAIT (pipeline flush): abort, go to IDLE on the next edge, `stallM` drops immediately, no write.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Reset values:
  - `stallM`=0, `errM`=0, `data_readM`=0, FSM in IDLE, counter 0.
  - Combinational outputs remain gated to these values while `rst_n`=0.
- Reset asserted mid-access aborts it. A store not yet committed is dropped.
- `stallM` is combinational from `memreqM` and state, so it is high in the request cycle itself.
- Load latency is W cycles after request. Store commit happens at the end of cycle T+W.
- Back-to-back requests:
  - The next request may be presented in cycle T+W+1 and is accepted from IDLE.
  - There are no idle bubbles between accesses.
- A read following a write to the same word sees the new data, because the write committed on the previous edge.
- `errM` is high only in the cycle the erroneous request is presented.

## Test plan
- Reset, then SW `0xDEADBEEF` @`0x10`, then LW @`0x10` (W=2):
  - `stallM` is high for 2 cycles per access.
  - The load returns `0xDEADBEEF` in its completion cycle.
- SB `0x80` @`0x13`, then LB @`0x13` and LBU @`0x13`:
  - LB returns `0xFFFFFF80`; LBU returns `0x00000080`.
  - LW @`0x10` returns `0x80ADBEEF`.
- SH `0x1234` @`0x22`, then LH/LHU @`0x22` both return `0x00001234`. SH `0x8001` @`0x22`, then LH returns `0xFFFF8001`.
- LW @`0x11`, SH @`0x21`, and a load with funct3=`011`:
  - Each gives `errM`=1 for one cycle, `stallM`=0 and `data_readM`=0.
  - Memory is unchanged: LW @`0x10` still returns `0x80ADBEEF`.
- Wrap-around with DEPTH_WORDS=1024:
  - SW `0x5A5A5A5A` @`0x1000`, then LW @`0x0000` returns `0x5A5A5A5A`.
- Abort cases:
  - SW @`0x40` with `memreqM` dropped after 1 stall cycle: LW @`0x40` returns the old value.
  - Separately, `rst_n` pulsed low during WAIT: all outputs go to 0 immediately and the FSM is in IDLE after release.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder for the M stage: wait-stated loads/stores over a word array,
// with byte/halfword lane selection, sign/zero extension and misalignment detection.
module dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memreqM,
  input  logic        memrwM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUresM,
  input  logic [31:0] data_writeM,
  output logic [31:0] data_readM,
  output logic        stallM,
  output logic        errM
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          unused_addr_hi;
  assign idx            = ALUresM[AW+1:2];
  assign lane           = ALUresM[1:0];
  assign unused_addr_hi = ^ALUresM[31:AW+2];

  logic        legal, misal, bad_access;
  logic [31:0] rword, shifted, load_data, wrep, wword;
  logic [15:0] half;
  logic [3:0]  be;
  logic        stall, done, err, we;

  always_comb begin
    legal = memrwM ? (funct3M <= 3'd2)
                   : (funct3M inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal = ((funct3M[1:0] == 2'b01) && lane[0]) ||
            ((funct3M[1:0] == 2'b10) && (lane != 2'b00));
    bad_access = !legal || misal;
  end

  always_comb begin
    rword   = mem_q[idx];
    shifted = rword >> {lane, 3'b000};
    half    = lane[1] ? rword[31:16] : rword[15:0];
    case (funct3M)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{half[15]}}, half};
      3'd2:    load_data = rword;
      3'd4:    load_data = {24'd0, shifted[7:0]};
      3'd5:    load_data = {16'd0, half};
      default: load_data = '0;
    endcase
  end

  // Store data is replicated across lanes so a byte-enable merge covers SB/SH/SW alike.
  always_comb begin
    case (funct3M)
      3'd0: begin
        be   = 4'b0001 << lane;
        wrep = {4{data_writeM[7:0]}};
      end
      3'd1: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{data_writeM[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = data_writeM;
      end
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      wword[i*8 +: 8] = be[i] ? wrep[i*8 +: 8] : rword[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memreqM) begin
          if (bad_access) begin
            err = 1'b1;
          end else if (WAIT_N == 4'd0) begin
            done = 1'b1;
          end else begin
            stall = 1'b1;
            if (WAIT_N == 4'd1) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
              cnt_d   = 4'd1;
            end
          end
        end
      end
      S_WAIT: begin
        if (!memreqM) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          if (cnt_q == WAIT_N - 4'd1) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done    = memreqM;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs and the write strobe are gated by rst_n so reset drops any pending store.
  always_comb begin
    stallM     = stall && rst_n;
    errM       = err && rst_n;
    we         = done && memrwM && rst_n;
    data_readM = (done && !memrwM && rst_n) ? load_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wword;
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: byte-level reference memory, randomized accesses,
// and a negedge monitor that checks each completion against queued expectations.
module tb_dmem_resp;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memreqM;
  logic        memrwM;
  logic [2:0]  funct3M;
  logic [31:0] ALUresM;
  logic [31:0] data_writeM;
  logic [31:0] data_readM;
  logic        stallM;
  logic        errM;

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .memreqM(memreqM), .memrwM(memrwM),
    .funct3M(funct3M), .ALUresM(ALUresM), .data_writeM(data_writeM),
    .data_readM(data_readM), .stallM(stallM), .errM(errM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [4:0]  stalls;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mdl [256];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic mdl_err(logic rw, logic [2:0] f3, logic [31:0] a);
    logic legal, mis;
    legal = rw ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = ((f3 == 3'd1 || f3 == 3'd5 || (rw && f3 == 3'd1)) && a[0]) ||
            (f3 == 3'd2 && a[1:0] != 2'b00);
    return !legal || mis;
  endfunction

  // Reference memory covers the first 64 words; higher address bits alias back onto it.
  function automatic logic [31:0] mdl_load(logic [2:0] f3, logic [31:0] a);
    int unsigned b;
    b = int'(a[7:0]);
    case (f3)
      3'd0:    return {{24{mdl[b][7]}}, mdl[b]};
      3'd1:    return {{16{mdl[b+1][7]}}, mdl[b+1], mdl[b]};
      3'd2:    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
      3'd4:    return {24'd0, mdl[b]};
      3'd5:    return {16'd0, mdl[b+1], mdl[b]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic mdl_store(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    int unsigned b;
    int unsigned n;
    b = int'(a[7:0]);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int unsigned i = 0; i < n; i++) mdl[b+i] = d[i*8 +: 8];
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: counts consecutive stall cycles and scores each completion cycle.
  int unsigned run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !memreqM) begin
      run = 0;
    end else if (stallM) begin
      run++;
      check("data_zero_while_stalled", data_readM, 32'd0);
    end else begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_completion: got completion, expected none");
      end else begin
        e = exp_q.pop_front();
        check("data_readM", data_readM, e.data);
        check("errM", 32'(errM), 32'(e.err));
        check("stall_cycles", 32'(run), 32'(e.stalls));
      end
      run = 0;
    end
  end

  task automatic do_req(logic rw, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    exp_t e;
    int unsigned budget;
    e.err    = mdl_err(rw, f3, a);
    e.data   = (rw || e.err) ? 32'd0 : mdl_load(f3, a);
    e.stalls = e.err ? 5'd0 : 5'(W);
    exp_q.push_back(e);
    memreqM = 1'b1; memrwM = rw; funct3M = f3; ALUresM = a; data_writeM = d;
    budget = 0;
    forever begin
      @(negedge clk);
      if (!stallM) break;
      budget++;
      if (budget > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stall_timeout: got stall > 20 cycles, expected %0d", W);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (rw && !e.err) mdl_store(f3, a, d);
  endtask

  task automatic idle_cycle();
    memreqM = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; memreqM = 1'b1; memrwM = 1'b0; funct3M = 3'd3;
    ALUresM = 32'h11; data_writeM = '0;
    #12;
    check("rst_stallM", 32'(stallM), 32'd0);
    check("rst_errM", 32'(errM), 32'd0);
    check("rst_data_readM", data_readM, 32'd0);
    memreqM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int unsigned i = 0; i < 64; i++) do_req(1'b1, 3'd2, 32'(i*4), $urandom);

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'd0);
    do_req(1'b1, 3'd0, 32'h13, 32'h80);
    do_req(1'b0, 3'd0, 32'h13, 32'd0);
    do_req(1'b0, 3'd4, 32'h13, 32'd0);
    do_req(1'b0, 3'd2, 32'h10, 32'd0);
    do_req(1'b1, 3'd1, 32'h22, 32'h1234);
    do_req(1'b0, 3'd1, 32'h22, 32'd0);
    do_req(1'b0, 3'd5, 32'h22, 32'd0);
    do_req(1'b1, 3'd1, 32'h22, 32'h8001);
    do_req(1'b0, 3'd1, 32'h22, 32'd0);
    do_req(1'b0, 3'd2, 32'h11, 32'd0);
    do_req(1'b1, 3'd1, 32'h21, 32'hFFFF);
    do_req(1'b0, 3'd3, 32'h10, 32'd0);
    do_req(1'b0, 3'd2, 32'h10, 32'd0);
    do_req(1'b1, 3'd2, 32'h1000, 32'h5A5A5A5A);
    do_req(1'b0, 3'd2, 32'h0, 32'd0);

    // Flush during WAIT: store must not commit and stall must drop at once.
    memreqM = 1'b1; memrwM = 1'b1; funct3M = 3'd2; ALUresM = 32'h40; data_writeM = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    memreqM = 1'b0;
    #1;
    check("abort_stallM", 32'(stallM), 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 3'd2, 32'h40, 32'd0);

    // Reset mid-access: outputs zero immediately, FSM idle afterwards.
    memreqM = 1'b1; memrwM = 1'b1; funct3M = 3'd2; ALUresM = 32'h44; data_writeM = 32'h0BADF00D;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstpulse_stallM", 32'(stallM), 32'd0);
    check("rstpulse_errM", 32'(errM), 32'd0);
    check("rstpulse_data", data_readM, 32'd0);
    memreqM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 3'd2, 32'h44, 32'd0);

    for (int unsigned i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = {18'd0, 2'($urandom_range(0, 3)), 4'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) idle_cycle();
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    idle_cycle();
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
